// File: rtl/instr_fetch_queue_if.sv
// Fetch-to-imem and fetch-to-decode signal bundle for instr_fetch_queue.
interface instr_fetch_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] PCF;
    logic            ReqF;
    logic            GntF;
    logic            RespValidF;
    logic [XLEN-1:0] RespInstrF;
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic            StallD;
    logic            ValidD;
    logic [XLEN-1:0] InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;

    // Fetch unit side
    modport master (
        output PCF, ReqF, ValidD, InstrD, PCD, PCPlus4D,
        input  GntF, RespValidF, RespInstrF, PCSrcE, PCTargetE, StallD
    );

    // Environment side (imem, EX redirect, decode)
    modport slave (
        input  PCF, ReqF, ValidD, InstrD, PCD, PCPlus4D,
        output GntF, RespValidF, RespInstrF, PCSrcE, PCTargetE, StallD
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues sequential PCs, buffers returned instructions in a small
// FIFO and presents the head to decode; EX redirects flush the queue.
module instr_fetch_queue #(
    parameter int unsigned    DEPTH    = 4,
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_queue_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

    logic [XLEN-1:0]  pcf_q, pcf_d;
    logic             pending_q, pending_d;
    logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0]  mem_instr_q [DEPTH];
    logic [XLEN-1:0]  mem_instr_d [DEPTH];
    logic [XLEN-1:0]  mem_pc_q    [DEPTH];
    logic [XLEN-1:0]  mem_pc_d    [DEPTH];

    logic             req_c, accept_c, push_c, pop_c, valid_c;
    logic [CNT_W:0]   inflight_c;

    // Request credit, handshake qualifiers and head-of-queue outputs
    always_comb begin
        inflight_c = {1'b0, count_q} + (CNT_W + 1)'(pending_q);
        valid_c    = (count_q != '0);
        req_c      = reset && !bus.PCSrcE && (inflight_c < (CNT_W + 1)'(DEPTH));
        accept_c   = req_c && bus.GntF;
        push_c     = bus.RespValidF && pending_q && !drop_q;
        pop_c      = valid_c && !bus.StallD;

        bus.PCF      = pcf_q;
        bus.ReqF     = req_c;
        bus.ValidD   = valid_c;
        bus.InstrD   = valid_c ? mem_instr_q[rd_ptr_q] : NOP_INSTR;
        bus.PCD      = valid_c ? mem_pc_q[rd_ptr_q] : '0;
        bus.PCPlus4D = valid_c ? (mem_pc_q[rd_ptr_q] + XLEN'(4)) : '0;
    end

    // Next-state: redirect flushes everything, otherwise accept/push/pop
    always_comb begin
        pcf_d       = pcf_q;
        pending_d   = pending_q;
        pend_pc_d   = pend_pc_q;
        drop_d      = 1'b0;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        mem_instr_d = mem_instr_q;
        mem_pc_d    = mem_pc_q;

        if (bus.PCSrcE) begin
            pcf_d     = bus.PCTargetE;
            pending_d = 1'b0;
            drop_d    = pending_q;
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
        end else begin
            pending_d = accept_c;
            if (accept_c) begin
                pend_pc_d = pcf_q;
                pcf_d     = pcf_q + XLEN'(4);
            end
            if (push_c) begin
                mem_instr_d[wr_ptr_q] = bus.RespInstrF;
                mem_pc_d[wr_ptr_q]    = pend_pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            pcf_q     <= RESET_PC;
            pending_q <= 1'b0;
            pend_pc_q <= '0;
            drop_q    <= 1'b0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_instr_q[i] <= '0;
                mem_pc_q[i]    <= '0;
            end
        end else begin
            pcf_q       <= pcf_d;
            pending_q   <= pending_d;
            pend_pc_q   <= pend_pc_d;
            drop_q      <= drop_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_instr_q <= mem_instr_d;
            mem_pc_q    <= mem_pc_d;
        end
    end
endmodule
